alu_operand_fetch: RTL and testbench
====================================

ALU_OPERAND_FETCH -- requirements
Module: alu_operand_fetch

Interface
REQ-001 Parameter DATA_W, default 32, operand and register width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width, giving 2**ADDR_W registers.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 we  input  1  register-file write enable.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 req_valid  input  1  operand-fetch request present.
REQ-010 req_ready  output  1  block can accept a request this cycle.
REQ-011 rs  input  ADDR_W  source address for operand a.
REQ-012 rt  input  ADDR_W  source address for operand b.
REQ-013 op_valid  output  1  a/b hold a valid operand pair for the downstream 32-bit ALU stage.
REQ-014 op_ready  input  1  downstream ALU stage consumes the pair this cycle.
REQ-015 a  output  DATA_W  operand a, registered.
REQ-016 b  output  DATA_W  operand b, registered.
REQ-017 issue_cnt  output  16  count of operand pairs handed downstream.

Function
REQ-018 The register file SHALL be 2**ADDR_W entries of DATA_W bits, written on the rising clk edge when we=1.
REQ-019 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored.
REQ-020 Accept SHALL occur when req_valid=1 and req_ready=1 at a rising edge.
REQ-021 req_ready SHALL equal (!op_valid || op_ready), combinationally.
REQ-022 On accept, a SHALL load reg[rs], b SHALL load reg[rt], and op_valid SHALL be 1 after that edge, giving 1-cycle latency.
REQ-023 Same-cycle bypass: if accept coincides with we=1 and waddr equals rs (nonzero), a SHALL load wdata; the same rule applies independently to rt and b.
REQ-024 If rs=rt, a and b SHALL load identical values, including under bypass.
REQ-025 Handoff SHALL occur when op_valid=1 and op_ready=1 at a rising edge.
REQ-026 On handoff without accept, op_valid SHALL clear to 0.
REQ-027 On handoff with accept in the same cycle, op_valid SHALL stay 1 and a/b SHALL load the new pair, with no bubble.
REQ-028 While op_valid=1 and op_ready=0, a, b and op_valid SHALL hold stable.
REQ-029 Captured a/b SHALL be a snapshot; later writes to rs/rt SHALL NOT alter held operands.
REQ-030 When op_valid=0, a/b SHALL retain their last values.
REQ-031 issue_cnt SHALL increment by 1 on each handoff and wrap from 0xFFFF to 0x0000.
REQ-032 Writes SHALL proceed every cycle regardless of handshake state.
REQ-033 Accept SHALL never occur while op_valid=1 and op_ready=0.

Reset
REQ-034 Reset assertion SHALL immediately clear all registers, a, b, op_valid and issue_cnt to 0, independent of clk.
REQ-035 Reset mid-transfer SHALL discard the held pair; after release, req_ready=1 and the first accept behaves as from power-up.
REQ-036 Writes and accepts presented while reset=1 SHALL be ignored.

Verification
REQ-037 Reset, then request rs=3, rt=0 -> a=0, b=0, op_valid=1 one cycle later, issue_cnt=0.
REQ-038 Write r1=0xFFFFFFFF and r2=0x00000000, request rs=1, rt=2 with op_ready=1 -> next cycle a=0xFFFFFFFF, b=0x00000000; after handoff issue_cnt=1.
REQ-039 Same cycle: we=1, waddr=5, wdata=0x12311111, request rs=5, rt=5 -> a=b=0x12311111.
REQ-040 Hold op_ready=0 for 3 cycles with the pair captured, rewrite the source regs, keep req_valid=1 -> a/b unchanged, req_ready=0, no accept; raising op_ready gives back-to-back handoff and accept.
REQ-041 Write waddr=0 with 0x11111000, then request rs=0 -> a=0.
REQ-042 Preload issue_cnt to 0xFFFF by 65535 handoffs, then 1 more handoff -> issue_cnt=0x0000; assert reset while op_valid=1 -> op_valid=0 and a=0 immediately.

Source files
------------

// File: rtl/alu_operand_fetch.sv
// rtl/alu_operand_fetch.sv - register file with registered operand-pair fetch stage
//
// Purpose:
//   Holds 2**ADDR_W registers of DATA_W bits (register 0 hard-wired to zero).
//   Accepts a fetch request (rs, rt), captures reg[rs]/reg[rt] into a/b one
//   cycle later, and hands the pair downstream with a valid/ready handshake.
//   A write to a source register in the same cycle as the fetch is bypassed.
//   Each handoff increments a 16-bit wrapping counter.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   we         in   register write enable
//   waddr      in   write address
//   wdata      in   write data
//   req_valid  in   fetch request present
//   req_ready  out  request can be accepted this cycle
//   rs, rt     in   source addresses for a and b
//   op_valid   out  a/b hold a valid pair
//   op_ready   in   downstream consumes the pair this cycle
//   a, b       out  registered operands
//   issue_cnt  out  number of pairs handed downstream (wraps)

module alu_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [15:0]       issue_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];

  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              accept, handoff;

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[ADDR_W'(i)] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      rf_q[waddr] <= wdata;
    end
  end

  always_comb begin
    // Read ports with same-cycle write bypass; address 0 overrides everything.
    rd_a = rf_q[rs];
    if (we && (waddr == rs)) rd_a = wdata;
    if (rs == '0) rd_a = '0;

    rd_b = rf_q[rt];
    if (we && (waddr == rt)) rd_b = wdata;
    if (rt == '0) rd_b = '0;

    accept  = req_valid && req_ready;
    handoff = op_valid_q && op_ready;

    op_valid_d = op_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;

    if (handoff) begin
      op_valid_d = 1'b0;
      cnt_d      = cnt_q + 16'd1;
    end
    // Accept after handoff so a simultaneous handoff+accept keeps op_valid high.
    if (accept) begin
      op_valid_d = 1'b1;
      a_d        = rd_a;
      b_d        = rd_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ready = !op_valid_q || op_ready;
  assign op_valid  = op_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb/tb_alu_operand_fetch.sv - self-checking bench for alu_operand_fetch

module tb_alu_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] rs = '0;
  logic [AW-1:0] rt = '0;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [15:0]   issue_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] m_rf [32];
  logic [DW-1:0] m_a, m_b;
  logic          m_valid;
  logic [15:0]   m_cnt;

  alu_operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .req_valid(req_valid), .req_ready(req_ready), .rs(rs), .rt(rt),
    .op_valid(op_valid), .op_ready(op_ready), .a(a), .b(b),
    .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] addr);
    if (addr == 0) return '0;
    if (we && waddr == addr) return wdata;
    return m_rf[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_a = '0; m_b = '0; m_valid = 1'b0; m_cnt = '0;
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic cycle();
    bit acc, hand;
    logic [DW-1:0] na, nb;
    acc  = req_valid && (!m_valid || op_ready);
    hand = m_valid && op_ready;
    na = m_read(rs);
    nb = m_read(rt);
    if (hand) begin m_cnt = m_cnt + 16'd1; m_valid = 1'b0; end
    if (acc)  begin m_a = na; m_b = nb; m_valid = 1'b1; end
    if (we && waddr != 0) m_rf[waddr] = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; req_valid = 1'b0; op_ready = 1'b0;
    waddr = '0; wdata = '0; rs = '0; rt = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    // Writes and requests during reset must be ignored.
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1; rs = 5'd3; rt = 5'd3; op_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
    n_cmp++; if (a !== '0 || b !== '0) begin n_err++; $display("FAIL reset_ab: got a=%h b=%h want 0/0", a, b); end
    n_cmp++; if (issue_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", issue_cnt); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_first_fetch();
    // rs=3 after reset: register 3 must read 0 despite the write held during reset.
    req_valid = 1'b1; rs = 5'd3; rt = 5'd0;
    cycle();
    req_valid = 1'b0;
    n_cmp++; if (a !== '0 || b !== '0) begin n_err++; $display("FAIL first_fetch_ab: got a=%h b=%h want 0/0", a, b); end
    n_cmp++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL first_fetch_valid: got %b want 1", op_valid); end
    n_cmp++; if (issue_cnt !== 16'd0) begin n_err++; $display("FAIL first_fetch_cnt: got %h want 0", issue_cnt); end
    op_ready = 1'b1;
    cycle();
    op_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] c0;
    c0 = m_cnt;
    we = 1'b1; waddr = 5'd1; wdata = 32'hFFFF_FFFF; cycle();
    waddr = 5'd2; wdata = 32'h0000_0000; cycle();
    we = 1'b0;
    req_valid = 1'b1; rs = 5'd1; rt = 5'd2; op_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    n_cmp++; if (a !== 32'hFFFF_FFFF || b !== 32'h0) begin n_err++; $display("FAIL basic_ab: got a=%h b=%h want ffffffff/00000000", a, b); end
    n_cmp++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", op_valid); end
    cycle();
    n_cmp++; if (issue_cnt !== c0 + 16'd1) begin n_err++; $display("FAIL basic_cnt: got %h want %h", issue_cnt, c0 + 16'd1); end
    n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", op_valid); end
    n_cmp++; if (a !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL basic_retain: got %h want ffffffff", a); end
    op_ready = 1'b0;
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd5; wdata = 32'h1231_1111;
    req_valid = 1'b1; rs = 5'd5; rt = 5'd5; op_ready = 1'b1;
    cycle();
    we = 1'b0; req_valid = 1'b0;
    n_cmp++; if (a !== 32'h1231_1111 || b !== 32'h1231_1111) begin n_err++; $display("FAIL bypass_ab: got a=%h b=%h want 12311111/12311111", a, b); end
    cycle();
    op_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] c0;
    we = 1'b1; waddr = 5'd6; wdata = 32'hAAAA_0006; cycle();
    waddr = 5'd7; wdata = 32'hBBBB_0007; cycle();
    we = 1'b0; req_valid = 1'b1; rs = 5'd6; rt = 5'd7; op_ready = 1'b0;
    cycle();
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; waddr = (i == 1) ? 5'd7 : 5'd6; wdata = 32'h5555_0000 + i;
      req_valid = 1'b1; rs = 5'd9; rt = 5'd10;
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", i, req_ready); end
      cycle();
      n_cmp++; if (a !== 32'hAAAA_0006 || b !== 32'hBBBB_0007 || op_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d]: got a=%h b=%h v=%b want aaaa0006/bbbb0007/1", i, a, b, op_valid);
      end
    end
    we = 1'b0; req_valid = 1'b1; rs = 5'd6; rt = 5'd7; op_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", req_ready); end
    cycle();
    n_cmp++; if (a !== 32'h5555_0002 || b !== 32'h5555_0001 || op_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_b2b: got a=%h b=%h v=%b want 55550002/55550001/1", a, b, op_valid);
    end
    n_cmp++; if (issue_cnt !== c0 + 16'd1) begin n_err++; $display("FAIL stall_cnt: got %h want %h", issue_cnt, c0 + 16'd1); end
    req_valid = 1'b0;
    cycle();
    op_ready = 1'b0;
  endtask

  task automatic test_reg0();
    we = 1'b1; waddr = 5'd0; wdata = 32'h1111_1000; cycle();
    we = 1'b0; req_valid = 1'b1; rs = 5'd0; rt = 5'd0; op_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    n_cmp++; if (a !== '0 || b !== '0) begin n_err++; $display("FAIL reg0_read: got a=%h b=%h want 0/0", a, b); end
    // Bypass must not apply to address 0 either.
    we = 1'b1; waddr = 5'd0; wdata = 32'h2222_2222; req_valid = 1'b1;
    cycle();
    we = 1'b0; req_valid = 1'b0;
    n_cmp++; if (a !== '0) begin n_err++; $display("FAIL reg0_bypass: got %h want 0", a); end
    cycle();
    op_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      we        = ($urandom_range(0, 1) == 1);
      waddr     = AW'($urandom_range(0, 7));
      wdata     = $urandom;
      req_valid = ($urandom_range(0, 3) != 0);
      rs        = AW'($urandom_range(0, 7));
      rt        = AW'($urandom_range(0, 7));
      op_ready  = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++; if (req_ready !== (!m_valid || op_ready)) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, (!m_valid || op_ready));
      end
      cycle();
      n_cmp++; if (a !== m_a || b !== m_b || op_valid !== m_valid || issue_cnt !== m_cnt) begin
        n_err++; $display("FAIL rand_state[%0d]: got a=%h b=%h v=%b c=%h want a=%h b=%h v=%b c=%h",
                          i, a, b, op_valid, issue_cnt, m_a, m_b, m_valid, m_cnt);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_wrap_and_reset();
    int budget;
    reset = 1'b1; #2; reset = 1'b0;
    model_reset();
    we = 1'b1; waddr = 5'd1; wdata = 32'hCAFE_F00D; cycle();
    we = 1'b0; req_valid = 1'b1; op_ready = 1'b1; rs = 5'd1; rt = 5'd1;
    budget = 70000;
    while (m_cnt != 16'hFFFF && budget > 0) begin
      cycle();
      budget--;
    end
    n_cmp++; if (budget == 0) begin n_err++; $display("FAIL wrap_budget: got model count %h want ffff", m_cnt); end
    n_cmp++; if (issue_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", issue_cnt); end
    cycle();
    n_cmp++; if (issue_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h want 0000", issue_cnt); end
    n_cmp++; if (op_valid !== 1'b1 || a !== 32'hCAFE_F00D) begin n_err++; $display("FAIL wrap_pre_reset: got v=%b a=%h want 1/cafef00d", op_valid, a); end
    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (op_valid !== 1'b0 || a !== '0 || b !== '0 || issue_cnt !== 16'd0) begin
      n_err++; $display("FAIL async_reset: got v=%b a=%h b=%h c=%h want 0/0/0/0", op_valid, a, b, issue_cnt);
    end
    @(posedge clk); #1;
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    req_valid = 1'b1; rs = 5'd1; rt = 5'd2;
    cycle();
    req_valid = 1'b0;
    n_cmp++; if (op_valid !== 1'b1 || a !== '0 || issue_cnt !== 16'd0) begin
      n_err++; $display("FAIL post_reset_fetch: got v=%b a=%h c=%h want 1/0/0", op_valid, a, issue_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_fetch();
    test_basic();
    test_bypass();
    test_stall();
    test_reg0();
    test_random();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
